hazard_scoreboard: RTL

- Parametrised successor to the pipeline RAW-stall unit.
- Replaces fixed stage-by-stage rd comparison with a per-register scoreboard:
  - fixed-latency producers are tracked by a countdown;
  - variable-latency producers (load, div) are tracked by a pending bit until write-back.
- Sits at decode/issue. Drives the pipeline stall and exposes per-source hazard status, an optional bypass-aware mode and a stall performance counter.

---
 rtl/hazard_scoreboard.sv | 97 +++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register RAW/WAW scoreboard for decode/issue: fixed-latency producers count down,
// variable-latency producers (load/div) hold a pending bit until their write-back arrives.
module hazard_scoreboard #(
  parameter int AW       = 5,
  parameter int NREG     = 32,
  parameter int NSRC     = 2,
  parameter int LAT_W    = 3,
  parameter int FWD_EN   = 0,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [NSRC*AW-1:0]  src_addr,
  input  logic [NSRC-1:0]     src_used,
  input  logic                issue_wen,
  input  logic [AW-1:0]       issue_rd,
  input  logic                issue_var,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd,
  input  logic                flush,
  output logic                stall,
  output logic [NSRC-1:0]     src_busy,
  output logic                waw_busy,
  output logic [NREG-1:0]     busy_vec,
  output logic [CNT_W-1:0]    stall_cnt
);

  // With a bypass network a result is consumable one cycle before its countdown expires.
  localparam logic [LAT_W-1:0] THRESH = (FWD_EN != 0) ? LAT_W'(1) : '0;

  logic [LAT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  var_bit;
  logic             fire;

  always_comb begin : src_check
    logic [AW-1:0] a;
    logic          rb;
    a        = '0;
    rb       = 1'b0;
    src_busy = '0;
    for (int i = 0; i < NSRC; i++) begin
      a  = src_addr[i*AW +: AW];
      rb = 1'b0;
      if (int'(a) < NREG) begin
        if (cnt[a] > THRESH) rb = 1'b1;
        // A var producer completing this very cycle can be bypassed straight to the consumer.
        if (var_bit[a] && !(FWD_EN != 0 && wb_valid && wb_rd == a)) rb = 1'b1;
      end
      src_busy[i] = src_used[i] & issue_valid & rb;
    end
  end

  // WAW looks at raw state only so that an older writer can never land after a younger one.
  always_comb begin
    waw_busy = 1'b0;
    if (issue_valid && issue_wen && int'(issue_rd) < NREG)
      waw_busy = (cnt[issue_rd] != '0) || var_bit[issue_rd];
  end

  assign stall = (|src_busy) | waw_busy;
  assign fire  = issue_valid & ~stall & ~flush;

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREG; r++)
      busy_vec[r] = (cnt[r] != '0) | var_bit[r];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      var_bit   <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        var_bit <= '0;
      end else begin
        for (int r = 0; r < NREG; r++) begin
          if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
          if (wb_valid && wb_rd == AW'(r)) var_bit[r] <= 1'b0;
          // Later assignments win: a new entry overrides the decrement/clear above.
          if (fire && issue_wen && issue_rd == AW'(r) && !(ZERO_REG != 0 && r == 0)) begin
            if (issue_var)              var_bit[r] <= 1'b1;
            else if (issue_lat != '0)   cnt[r]     <= issue_lat;
          end
        end
      end
      if (issue_valid && stall && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
